// File: rtl/cic_pkg.sv
// Shared sizing helpers for the multi-channel CIC interpolator.
package cic_pkg;

  // Accumulator width that holds the worst-case integrator growth R^(N-1)
  // on top of the input word plus one bit of headroom per stage.
  function automatic int acc_width(input int isz, input int n, input int maxl);
    return isz + n + (n - 1) * maxl;
  endfunction

  // Width of the gain-normalising right shift, (N-1)*log2(R) at most.
  function automatic int sh_width(input int n, input int maxl);
    int w;
    w = $clog2((n - 1) * maxl + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Upper saturation bound for an OSZ-bit signed output.
  function automatic longint sat_max(input int osz);
    return (64'sd1 <<< (osz - 1)) - 64'sd1;
  endfunction

  // Lower saturation bound for an OSZ-bit signed output.
  function automatic longint sat_min(input int osz);
    return -(64'sd1 <<< (osz - 1));
  endfunction

endpackage

// File: rtl/cic_round_sat.sv
// One channel of the output path: normalising arithmetic shift with
// round-half-up, extra gain shift, then clip to the output word.
module cic_round_sat
  import cic_pkg::*;
#(
  parameter int ASZ = 35,
  parameter int OSZ = 16,
  parameter int SHW = 5
) (
  input  logic signed [ASZ-1:0] i_acc,
  input  logic        [SHW-1:0] i_shift,
  input  logic        [1:0]     i_gain,
  output logic signed [OSZ-1:0] o_data,
  output logic                  o_clip
);

  localparam logic signed [ASZ+3:0] MAXV = {{(ASZ+5-OSZ){1'b0}}, {(OSZ-1){1'b1}}};
  localparam logic signed [ASZ+3:0] MINV = {{(ASZ+5-OSZ){1'b1}}, {(OSZ-1){1'b0}}};

  logic signed [ASZ:0]   w_ext;
  logic signed [ASZ:0]   w_half;
  logic signed [ASZ:0]   w_sum;
  logic signed [ASZ:0]   w_shr;
  logic signed [ASZ+3:0] w_gain;

  // One extra bit keeps the rounding add from wrapping; a zero shift needs no rounding.
  always_comb begin
    w_ext  = {i_acc[ASZ-1], i_acc};
    w_half = (i_shift == '0) ? '0 : ((ASZ+1)'(1) << (i_shift - SHW'(1)));
    w_sum  = w_ext + w_half;
    w_shr  = w_sum >>> i_shift;
    w_gain = {{3{w_shr[ASZ]}}, w_shr} <<< i_gain;
  end

  // Clip to the signed output range and flag any clip.
  always_comb begin
    o_clip = 1'b0;
    o_data = w_gain[OSZ-1:0];
    if (w_gain > MAXV) begin
      o_data = MAXV[OSZ-1:0];
      o_clip = 1'b1;
    end else if (w_gain < MINV) begin
      o_data = MINV[OSZ-1:0];
      o_clip = 1'b1;
    end
  end

endmodule

// File: rtl/cic_interpolator_mc.sv
// Multi-channel CIC interpolator, ratio R = 2^rate_log2 latched on enable rise.
// Combs run on comb ticks (out_stb at phase 0) with a combinational difference
// chain over registered delays; integrator 0 absorbs the comb result on the
// tick itself, so an impulse consumed on tick T reaches out_data in the cycle
// after the NUM_STAGES-th out_stb following T (N+1 strobes counting T).
module cic_interpolator_mc
  import cic_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int NUM_STAGES    = 3,
  parameter int MAX_RATE_LOG2 = 8,
  parameter int ISZ           = 16,
  parameter int OSZ           = 16,
  localparam int ASZ = acc_width(ISZ, NUM_STAGES, MAX_RATE_LOG2),
  localparam int RLW = $clog2(MAX_RATE_LOG2 + 1),
  localparam int SHW = sh_width(NUM_STAGES, MAX_RATE_LOG2)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [RLW-1:0]        rate_log2,
  input  logic [1:0]            gain_log2,
  input  logic                  out_stb,
  input  logic [NUM_CH*ISZ-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_CH*OSZ-1:0] out_data,
  output logic                  out_valid,
  output logic                  underrun,
  output logic                  sat
);

  logic                          r_en_d;
  logic [RLW-1:0]                r_rate;
  logic [1:0]                    r_gain;
  logic [MAX_RATE_LOG2-1:0]      r_phase;
  logic                          r_buf_full;
  logic [NUM_CH-1:0][ISZ-1:0]    r_buf;
  logic [NUM_CH*OSZ-1:0]         r_out_data;
  logic                          r_out_valid;
  logic                          r_underrun;
  logic                          r_sat;

  logic                          w_rise;
  logic [RLW-1:0]                w_rate;
  logic [1:0]                    w_gain;
  logic [MAX_RATE_LOG2:0]        w_rmask;
  logic                          w_tick;
  logic                          w_accept;
  logic                          w_starve;
  logic [NUM_CH-1:0][ISZ-1:0]    w_in;
  logic [NUM_CH-1:0][ISZ-1:0]    w_src;
  logic [SHW-1:0]                w_shift;
  logic [NUM_CH-1:0][OSZ-1:0]    w_rs;
  logic [NUM_CH-1:0]             w_clip;

  // Config seen on the rising edge of enable is used immediately, then held.
  always_comb begin
    w_rise   = enable & ~r_en_d;
    w_rate   = w_rise ? rate_log2 : r_rate;
    w_gain   = w_rise ? gain_log2 : r_gain;
    w_rmask  = ((MAX_RATE_LOG2+1)'(1) << w_rate) - (MAX_RATE_LOG2+1)'(1);
    w_tick   = enable & out_stb & (r_phase == '0);
    w_in     = in_data;
    in_ready = enable & ~r_buf_full;
    w_accept = in_valid & in_ready;
    w_starve = w_tick & ~r_buf_full & ~in_valid;
    w_shift  = SHW'((NUM_STAGES - 1) * int'(w_rate));
    // Buffered sample first, else same-cycle bypass, else zeros.
    if (r_buf_full)    w_src = r_buf;
    else if (in_valid) w_src = w_in;
    else               w_src = '0;
  end

  // Enable edge detect and config latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_d <= 1'b0;
      r_rate <= '0;
      r_gain <= '0;
    end else begin
      r_en_d <= enable;
      if (w_rise) begin
        r_rate <= rate_log2;
        r_gain <= gain_log2;
      end
    end
  end

  // Output-rate phase counter, wraps at R-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_phase <= '0;
    else if (!enable) r_phase <= '0;
    else if (out_stb) r_phase <= ({1'b0, r_phase} == w_rmask) ? '0 : r_phase + MAX_RATE_LOG2'(1);
  end

  // Single-entry input buffer: drained on every comb tick, filled between ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
    end else if (!enable) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
    end else if (w_tick) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf      <= w_in;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NUM_STAGES:0][ASZ-1:0]   w_cin;
    logic [NUM_STAGES-1:0][ASZ-1:0] r_cdly;
    logic [NUM_STAGES-1:0][ASZ-1:0] r_int;

    assign w_cin[0] = {{(ASZ-ISZ){w_src[c][ISZ-1]}}, w_src[c]};
    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_comb
      assign w_cin[s+1] = w_cin[s] - r_cdly[s];
    end

    // Comb delays advance on ticks; integrators advance on every strobe, zero-stuffed.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cdly <= '0;
        r_int  <= '0;
      end else if (!enable) begin
        r_cdly <= '0;
        r_int  <= '0;
      end else begin
        if (w_tick) begin
          for (int s = 0; s < NUM_STAGES; s++) r_cdly[s] <= w_cin[s];
        end
        if (out_stb) begin
          r_int[0] <= r_int[0] + (w_tick ? w_cin[NUM_STAGES] : '0);
          for (int s = 1; s < NUM_STAGES; s++) r_int[s] <= r_int[s] + r_int[s-1];
        end
      end
    end

    cic_round_sat #(.ASZ(ASZ), .OSZ(OSZ), .SHW(SHW)) u_rs (
      .i_acc  ($signed(r_int[NUM_STAGES-1])),
      .i_shift(w_shift),
      .i_gain (w_gain),
      .o_data (w_rs[c]),
      .o_clip (w_clip[c])
    );
  end

  // Output register, valid pulse and sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_underrun  <= 1'b0;
      r_sat       <= 1'b0;
    end else if (!enable) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_underrun  <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= out_stb;
      if (out_stb) begin
        r_out_data <= w_rs;
        if (|w_clip) r_sat <= 1'b1;
      end
      if (w_starve) r_underrun <= 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign underrun  = r_underrun;
  assign sat       = r_sat;

endmodule

// File: tb/tb_cic_interpolator_mc.sv
// Directed bench for cic_interpolator_mc: each task drives one scenario and
// compares against hand-derived values (NUM_CH=2, N=3, 16-bit words).
module tb_cic_interpolator_mc;

  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        reset_n, enable, out_stb, in_valid;
  logic [3:0]  rate_log2;
  logic [1:0]  gain_log2;
  logic [31:0] in_data;
  logic        in_ready, out_valid, underrun, sat;
  logic [31:0] out_data;

  int vecs = 0;
  int errs = 0;
  int q0[$], q1[$];
  int dc0, dc1, acc_cnt;
  bit src_en, from_q;

  cic_interpolator_mc dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rate_log2(rate_log2),
    .gain_log2(gain_log2), .out_stb(out_stb), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .underrun(underrun), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int och(input int c);
    return $signed(out_data[c*16 +: 16]);
  endfunction

  // Source: queued samples first, then a constant level.
  task automatic present();
    in_valid = src_en;
    from_q   = (q0.size() > 0);
    if (from_q) in_data = {16'(q1[0]), 16'(q0[0])};
    else        in_data = {16'(dc1), 16'(dc0)};
  endtask

  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready) begin
      acc_cnt++;
      if (from_q) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
    end
    @(posedge clk);
    #1;
    present();
  endtask

  task automatic start(input int r, input int g);
    enable = 1'b0;
    step();
    rate_log2 = 4'(r);
    gain_log2 = 2'(g);
    enable    = 1'b1;
    present();
  endtask

  task automatic test_reset();
    repeat (3) step();
    vecs++;
    if (out_data !== 0 || out_valid !== 0 || in_ready !== 0 || underrun !== 0 || sat !== 0) begin
      errs++;
      $display("FAIL reset_init: data=%h v=%b rdy=%b ur=%b sat=%b, want all 0", out_data, out_valid, in_ready, underrun, sat);
    end
    reset_n = 1'b1;
    dc0 = 1234; dc1 = -55; src_en = 1'b1;
    start(2, 0);
    repeat (10) step();
    vecs++;
    if (out_valid !== 1'b1) begin
      errs++; $display("FAIL run_valid: out_valid=%b want 1", out_valid);
    end
    #2; reset_n = 1'b0; enable = 1'b0; #1;
    vecs++;
    if (out_data !== 0 || out_valid !== 0 || in_ready !== 0 || underrun !== 0 || sat !== 0) begin
      errs++;
      $display("FAIL reset_async: data=%h v=%b rdy=%b ur=%b sat=%b, want all 0", out_data, out_valid, in_ready, underrun, sat);
    end
    step(); step();
    reset_n = 1'b1;
    repeat (3) step();
    vecs++;
    if (out_data !== 0 || out_valid !== 0 || in_ready !== 0) begin
      errs++; $display("FAIL idle: data=%h v=%b rdy=%b, want 0 0 0", out_data, out_valid, in_ready);
    end
    enable = 1'b1; #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL ready_on_enable: in_ready=%b want 1", in_ready);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_dc();
    bit over, bad;
    over = 0; bad = 0;
    dc0 = 1000; dc1 = -1000; src_en = 1'b1;
    start(2, 0);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (och(0) > 1000 || och(1) < -1000) over = 1;
      if (i >= 18 && (och(0) != 1000 || och(1) != -1000)) bad = 1;
    end
    vecs++;
    if (over) begin errs++; $display("FAIL dc_overshoot: saw |out| above 1000"); end
    vecs++;
    if (bad) begin
      errs++; $display("FAIL dc_settle: ch0=%0d ch1=%0d want 1000 -1000", och(0), och(1));
    end
    vecs++;
    if (underrun !== 0 || sat !== 0) begin
      errs++; $display("FAIL dc_flags: underrun=%b sat=%b want 0 0", underrun, sat);
    end
  endtask

  task automatic test_passthrough();
    int exp0;
    dc0 = 0; dc1 = 0; src_en = 1'b1;
    start(0, 0);
    repeat (6) step();
    q0.push_back(5); q1.push_back(0);
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      exp0 = (k == NS + 1) ? 5 : 0;
      vecs++;
      if (och(0) != exp0 || och(1) != 0 || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL passthru_k%0d: ch0=%0d ch1=%0d v=%b want %0d 0 1", k, och(0), och(1), out_valid, exp0);
      end
    end
    vecs++;
    if (underrun !== 0) begin errs++; $display("FAIL passthru_underrun: %b want 0", underrun); end
  endtask

  task automatic test_round();
    int e0[5] = '{1, 2, 2, 1, 0};
    int e1[5] = '{0, -1, -1, 0, 0};
    bit found;
    dc0 = 0; dc1 = 0; src_en = 1'b1;
    start(1, 0);
    repeat (10) step();
    q0.push_back(2); q1.push_back(-2);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (och(0) != 0) found = 1;
    end
    vecs++;
    if (!found) begin
      errs++; $display("FAIL round_timeout: no response within 30 strobes");
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (k > 0) step();
        vecs++;
        if (och(0) != e0[k] || och(1) != e1[k]) begin
          errs++;
          $display("FAIL round_k%0d: ch0=%0d ch1=%0d want %0d %0d", k, och(0), och(1), e0[k], e1[k]);
        end
      end
    end
  endtask

  task automatic test_sat();
    dc0 = 1000; dc1 = -1000; src_en = 1'b1;
    start(0, 1);
    repeat (8) step();
    vecs++;
    if (och(0) != 2000 || och(1) != -2000 || sat !== 0) begin
      errs++; $display("FAIL gain_x2: ch0=%0d ch1=%0d sat=%b want 2000 -2000 0", och(0), och(1), sat);
    end
    dc0 = 20000; dc1 = -20000;
    repeat (8) step();
    vecs++;
    if (och(0) != 32767 || och(1) != -32768 || sat !== 1) begin
      errs++; $display("FAIL sat_clip: ch0=%0d ch1=%0d sat=%b want 32767 -32768 1", och(0), och(1), sat);
    end
    dc0 = -20000; dc1 = 20000;
    repeat (8) step();
    vecs++;
    if (och(0) != -32768 || och(1) != 32767) begin
      errs++; $display("FAIL sat_neg: ch0=%0d ch1=%0d want -32768 32767", och(0), och(1));
    end
  endtask

  task automatic test_backpressure();
    dc0 = 300; dc1 = -300; src_en = 1'b1;
    start(3, 0);
    repeat (16) step();
    acc_cnt = 0;
    repeat (64) step();
    vecs++;
    if (acc_cnt != 8) begin errs++; $display("FAIL accept_rate: %0d accepts in 64 strobes want 8", acc_cnt); end
    vecs++;
    if (och(0) != 300 || och(1) != -300 || underrun !== 0) begin
      errs++; $display("FAIL r8_dc: ch0=%0d ch1=%0d ur=%b want 300 -300 0", och(0), och(1), underrun);
    end
    src_en = 1'b0; present();
    repeat (16) step();
    vecs++;
    if (underrun !== 1'b1) begin errs++; $display("FAIL underrun_set: %b want 1", underrun); end
    repeat (40) step();
    vecs++;
    if (och(0) != 0 || och(1) != 0) begin
      errs++; $display("FAIL underrun_zeros: ch0=%0d ch1=%0d want 0 0", och(0), och(1));
    end
  endtask

  task automatic test_flush();
    dc0 = 20000; dc1 = 0; src_en = 1'b1;
    start(0, 1);
    repeat (8) step();
    src_en = 1'b0; present();
    repeat (4) step();
    vecs++;
    if (sat !== 1'b1 || underrun !== 1'b1) begin
      errs++; $display("FAIL flush_pre: sat=%b underrun=%b want 1 1", sat, underrun);
    end
    enable = 1'b0;
    step();
    vecs++;
    if (out_data !== 0 || out_valid !== 0 || in_ready !== 0 || underrun !== 0 || sat !== 0) begin
      errs++;
      $display("FAIL flush: data=%h v=%b rdy=%b ur=%b sat=%b, want all 0", out_data, out_valid, in_ready, underrun, sat);
    end
    dc0 = 1000; dc1 = -1000; src_en = 1'b1;
    rate_log2 = 4'd3; gain_log2 = 2'd0; enable = 1'b1;
    present();
    step();
    rate_log2 = 4'd0; gain_log2 = 2'd3;
    repeat (15) step();
    acc_cnt = 0;
    repeat (64) step();
    vecs++;
    if (acc_cnt != 8) begin errs++; $display("FAIL relatch_rate: %0d accepts in 64 strobes want 8", acc_cnt); end
    vecs++;
    if (och(0) != 1000 || och(1) != -1000) begin
      errs++; $display("FAIL relatch_dc: ch0=%0d ch1=%0d want 1000 -1000", och(0), och(1));
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; out_stb = 1'b1; in_valid = 1'b0; in_data = '0;
    rate_log2 = '0; gain_log2 = '0; src_en = 1'b0; from_q = 1'b0;
    dc0 = 0; dc1 = 0; acc_cnt = 0;
    test_reset();
    test_dc();
    test_passthrough();
    test_round();
    test_sat();
    test_backpressure();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cic_interpolator_mc.md
Name: cic_interpolator_mc

Overview:
Multi-channel CIC interpolator with a runtime-selectable power-of-two ratio, an input valid/ready handshake and automatic gain normalisation. The output is rounded and saturated, with an optional extra gain boost. It sits between the baseband sample source and the DAC/upconverter path, replacing the fixed-ratio single-channel interpolator. All channels share one rate schedule, and each channel has its own comb/integrator datapath.

Parameters:
NUM_CH, 2, number of parallel channels (e.g. I/Q)
NUM_STAGES, 3, comb/integrator stage count N (>=1)
MAX_RATE_LOG2, 8, largest supported log2(R)
ISZ, 16, input word size per channel
OSZ, 16, output word size per channel
ASZ (local), ISZ + NUM_STAGES + (NUM_STAGES-1)*MAX_RATE_LOG2, internal accumulator width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run/flush control
rate_log2  in  clog2(MAX_RATE_LOG2+1)  log2 of interpolation ratio R, range 0..MAX_RATE_LOG2
gain_log2  in  2  extra left shift applied before saturation, range 0..3
out_stb  in  1  output-rate tick, one-cycle pulse
in_data  in  NUM_CH*ISZ  packed signed samples; channel 0 occupies the LSBs
in_valid  in  1  input sample offered
in_ready  out  1  block can accept a sample
out_data  out  NUM_CH*OSZ  packed signed output samples
out_valid  out  1  one-cycle pulse marking a new out_data
underrun  out  1  sticky: a comb tick occurred with no input available
sat  out  1  sticky: an output was clipped on any channel

Behaviour:
- Reset (async, reset_n=0) clears every register. Outputs: out_data=0, out_valid=0, in_ready=0, underrun=0, sat=0.
- Config latch: rate_log2 and gain_log2 are captured when enable rises. Changes to either while enable=1 are ignored.
- enable=0 is a synchronous flush:
  - phase counter, input buffer, combs, integrators, out_data and both sticky flags are cleared;
  - in_ready=0 and out_valid=0.
- Phase counter counts out_stb pulses from 0 to R-1, where R=2^rate_log2, then wraps to 0.
- A comb tick is out_stb=1 with phase=0.
- Input buffer: one entry, holding all channels.
  - in_ready = enable & !buf_full.
  - A sample is accepted when in_valid & in_ready.
  - At a comb tick the buffer is consumed and buf_full clears.
  - If the buffer is empty at a comb tick but in_valid=1 in that same cycle, in_data bypasses straight into comb stage 0 and is counted as accepted. This is not an underrun.
  - If neither the buffer nor the bypass supplies data at a comb tick, zeros are fed on all channels and underrun is set.
- Combs:
  - NUM_STAGES registered difference stages, updated only on comb ticks.
  - Input is sign-extended to ASZ bits.
- Integrators:
  - NUM_STAGES registered accumulators, updated on every out_stb.
  - Stage 0 adds the last comb output on comb ticks and adds 0 on all other ticks (zero-stuffing).
  - Integrators use two's-complement wrap-around and never saturate.
- Output path, per channel, on each out_stb:
  - t = last integrator >>> ((NUM_STAGES-1)*rate_log2), rounded half-up by adding 1 at the bit below the cut. This gives unity DC gain.
  - t is then shifted left by gain_log2.
  - The result is saturated to OSZ bits: [-2^(OSZ-1), 2^(OSZ-1)-1]. Any clip on any channel sets sat.
  - out_data is registered 1 cycle after out_stb, and out_valid pulses in that same cycle.
- Latency: an impulse on a comb tick first appears on out_data at the (NUM_STAGES+1)th out_stb after that tick, plus 1 cycle.
- DC: a constant input X with gain_log2=0 settles to exactly X, with no overshoot.
- rate_log2=0: passthrough of the input with the fixed latency above.
- out_stb pulses every cycle are legal. The block never stalls out_stb.

Decomposition:
- Shared package cic_pkg:
  - acc_width(ISZ, N, MAXL) function;
  - shift-amount width constant;
  - sat/round helper function prototypes.
- One sub-module, cic_round_sat: combinational arithmetic-shift, round-half-up, gain shift and saturate for one channel. Instantiate it NUM_CH times.
- Comb and integrator chains are generate loops over channel and stage.

Test Plan:
1. Reset and idle: assert reset_n=0 mid-run, then release with enable=0 → all outputs 0; in_ready stays 0 until enable=1.
2. DC, R=4 (rate_log2=2), out_stb every cycle, ch0=1000 and ch1=-1000 → out_data settles to 1000/-1000 exactly within 4*NUM_STAGES+NUM_STAGES+2 ticks; underrun=0 and sat=0.
3. Passthrough: rate_log2=0, impulse of 5 on ch0 → a single 5 appears on out_data after NUM_STAGES+1 ticks plus 1 cycle, and 0 at all other ticks.
4. Saturation: gain_log2=1, DC 20000 → out 32767 and sat=1; DC -20000 → -32768.
5. Underrun and backpressure: R=8 with in_valid low for one input period → underrun=1 and zeros enter the comb; in_valid held high → exactly one acceptance per 8 out_stb.
6. Flush: drop enable mid-stream → next cycle all state is zero and the sticky flags are cleared; re-enable with rate_log2=3 → the new ratio takes effect, and a rate_log2 change while enabled is ignored.
